// File: rtl/byte_mem_arbiter.sv
// Arbitrates a byte-wide memory between a read-only fetch port (I) and a load/store port (D),
// splitting each 32-bit word access into four big-endian byte beats.
module byte_mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t              state;
    logic [1:0]          beat;
    logic                grant_d;
    logic                last_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [23:0]         rbuf;

    logic                pick_d;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;

    // D wins when it is the only requester, under fixed priority, or when I was served last.
    assign pick_d    = d_req && (!i_req || !FAIR || !last_d);
    assign sel_addr  = pick_d ? d_addr : i_addr;
    assign sel_wdata = pick_d ? d_wdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= 2'd0;
            grant_d <= 1'b0;
            last_d  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rbuf    <= 24'h0;
            i_rdata <= 32'h0;
            i_ack   <= 1'b0;
            d_rdata <= 32'h0;
            d_ack   <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= 8'h0;
            busy    <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_d <= pick_d;
                        we_q    <= pick_d && d_we;
                        addr_q  <= sel_addr;
                        wdata_q <= {sel_wdata[23:0], 8'h00};
                        beat    <= 2'd0;
                        m_en    <= 1'b1;
                        m_we    <= pick_d && d_we;
                        m_addr  <= sel_addr;
                        m_wdata <= sel_wdata[31:24];
                        busy    <= 1'b1;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    // Read bytes arrive one cycle behind their beat; shift them in big-endian order.
                    if (!we_q && beat != 2'd0) begin
                        rbuf <= {rbuf[15:0], m_rdata};
                    end
                    if (beat == 2'd3) begin
                        m_en <= 1'b0;
                        m_we <= 1'b0;
                        if (we_q) begin
                            d_ack <= grant_d;
                            i_ack <= !grant_d;
                            state <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        beat    <= beat + 2'd1;
                        m_addr  <= addr_q + ADDR_W'(beat + 2'd1);
                        m_wdata <= wdata_q[31:24];
                        wdata_q <= {wdata_q[23:0], 8'h00};
                    end
                end
                DRAIN: begin
                    if (grant_d) begin
                        d_ack   <= 1'b1;
                        d_rdata <= {rbuf, m_rdata};
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= {rbuf, m_rdata};
                    end
                    state <= DONE;
                end
                DONE: begin
                    last_d <= grant_d;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
